mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage.sv | 86 ++++++++
 tb/tb_mem_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-to-memory stage bundle with writeback results and stall back-pressure.
interface mem_stage_if;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        flush;
  logic        mem_stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        misalign_err;
  modport master (
    output alu_result, store_data, rd, mem_read, mem_write, reg_write, flush,
    input  mem_stall, wb_data, wb_rd, wb_reg_write, misalign_err
  );
  modport slave (
    input  alu_result, store_data, rd, mem_read, mem_write, reg_write, flush,
    output mem_stall, wb_data, wb_rd, wb_reg_write, misalign_err
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with word RAM, 2-cycle loads, 1-cycle ALU passthrough.
// Optional MEM_MISALIGN_CHECK_EN turns misaligned loads/stores into bubbles and sets a sticky error.
module mem_stage #(
  parameter int DEPTH_LOG2 = 8
) (
  input logic       clk,
  input logic       reset,
  mem_stage_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t                state, state_nxt;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx, lat_idx;
  logic [4:0]            lat_rd;
  logic                  lat_rw;
  logic                  mis, mem_we, take_load, wb_alu, wb_mem, err_set;
  assign idx = bus.alu_result[DEPTH_LOG2+1:2];
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = |bus.alu_result[1:0];
`else
  assign mis = 1'b0;
`endif
  assign bus.mem_stall = (state == RD_WAIT);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  // Any access that is not a clean load, store or ALU op leaves a bubble on writeback.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    take_load = 1'b0;
    wb_alu    = 1'b0;
    wb_mem    = 1'b0;
    err_set   = 1'b0;
    if (state == RD_WAIT) begin
      state_nxt = IDLE;
      wb_mem    = !bus.flush;
    end else if (!bus.flush) begin
      if (bus.mem_read || bus.mem_write) begin
        err_set   = mis;
        take_load = !mis && bus.mem_read;
        mem_we    = !mis && !bus.mem_read;
        state_nxt = take_load ? RD_WAIT : IDLE;
      end else begin
        wb_alu = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (mem_we && !reset) mem[idx] <= bus.store_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wb_data      <= '0;
      bus.wb_rd        <= '0;
      bus.wb_reg_write <= 1'b0;
      lat_idx          <= '0;
      lat_rd           <= '0;
      lat_rw           <= 1'b0;
    end else begin
      if (take_load) begin
        lat_idx <= idx;
        lat_rd  <= bus.rd;
        lat_rw  <= bus.reg_write;
      end
      if (wb_alu) begin
        bus.wb_data      <= bus.alu_result;
        bus.wb_rd        <= bus.rd;
        bus.wb_reg_write <= bus.reg_write && (bus.rd != 5'd0);
      end else if (wb_mem) begin
        bus.wb_data      <= mem[lat_idx];
        bus.wb_rd        <= lat_rd;
        bus.wb_reg_write <= lat_rw && (lat_rd != 5'd0);
      end else begin
        bus.wb_reg_write <= 1'b0;
      end
    end
  end
`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset)
    if (reset)        bus.misalign_err <= 1'b0;
    else if (err_set) bus.misalign_err <= 1'b1;
`else
  assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a cycle-level reference model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  mem_stage_if bus ();
  mem_stage #(.DEPTH_LOG2(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] mem_m [int];
  bit          busy;
  int          p_idx;
  logic [4:0]  p_rd;
  bit          p_rw;
  logic [31:0] e_data;
  logic [4:0]  e_rd;
  bit          e_rw, e_err, known;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_outputs(input string tag);
    check({tag, ".stall"}, {31'd0, bus.mem_stall}, {31'd0, busy});
    check({tag, ".wb_we"}, {31'd0, bus.wb_reg_write}, {31'd0, e_rw});
    check({tag, ".wb_rd"}, {27'd0, bus.wb_rd}, {27'd0, e_rd});
    check({tag, ".err"}, {31'd0, bus.misalign_err}, {31'd0, e_err});
    if (known) check({tag, ".wb_data"}, bus.wb_data, e_data);
  endtask
  task automatic model_reset();
    busy = 0; e_data = 0; e_rd = 0; e_rw = 0; e_err = 0; known = 1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  // One instruction slot: drive inputs, predict the outcome, clock, compare.
  task automatic step(input string tag, input bit rd_en, input bit wr_en, input bit rw,
                      input bit fl, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    int idx;
    bus.mem_read = rd_en; bus.mem_write = wr_en; bus.reg_write = rw; bus.flush = fl;
    bus.alu_result = a; bus.store_data = sd; bus.rd = r;
    idx = int'(a[9:2]);
    if (busy) begin
      busy = 0;
      if (fl) e_rw = 0;
      else begin
        known = mem_m.exists(p_idx);
        if (known) e_data = mem_m[p_idx];
        e_rd = p_rd;
        e_rw = p_rw && p_rd != 0;
      end
    end else if (fl) e_rw = 0;
    else if (rd_en || wr_en) begin
      e_rw = 0;
      if (MIS && a[1:0] != 2'b00) e_err = 1;
      else if (rd_en) begin busy = 1; p_idx = idx; p_rd = r; p_rw = rw; end
      else mem_m[idx] = sd;
    end else begin
      e_data = a; e_rd = r; e_rw = rw && r != 0; known = 1;
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask
  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
  endtask
  initial begin
    bus.mem_read = 0; bus.mem_write = 0; bus.reg_write = 0; bus.flush = 0;
    bus.alu_result = 0; bus.store_data = 0; bus.rd = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    step("alu", 0, 0, 1, 0, 32'h11, 32'h0, 5'd5);
    check("alu_data", bus.wb_data, 32'h11);
    check("alu_rd", {27'd0, bus.wb_rd}, 32'd5);
    check("alu_we", {31'd0, bus.wb_reg_write}, 32'd1);
    step("st40", 0, 1, 0, 0, 32'h40, 32'hDEADBEEF, 5'd0);
    step("ld40", 1, 0, 1, 0, 32'h40, 32'h0, 5'd3);
    check("ld40_stall", {31'd0, bus.mem_stall}, 32'd1);
    step("ld40_wait", 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h5, 5'd7);
    check("ld40_data", bus.wb_data, 32'hDEADBEEF);
    check("ld40_rd", {27'd0, bus.wb_rd}, 32'd3);
    check("ld40_we", {31'd0, bus.wb_reg_write}, 32'd1);
    step("st400", 0, 1, 0, 0, 32'h400, 32'h1234, 5'd0);
    step("ld0", 1, 0, 1, 0, 32'h0, 32'h0, 5'd9);
    idle("ld0_wait");
    check("wrap_data", bus.wb_data, 32'h1234);
    step("ldf", 1, 0, 1, 0, 32'h40, 32'h0, 5'd4);
    step("ldf_flush", 0, 0, 0, 1, 32'h0, 32'h0, 5'd0);
    check("flush_we", {31'd0, bus.wb_reg_write}, 32'd0);
    check("flush_idle", {31'd0, bus.mem_stall}, 32'd0);
    step("ld40b", 1, 0, 1, 0, 32'h40, 32'h0, 5'd6);
    idle("ld40b_wait");
    check("ld40b_data", bus.wb_data, 32'hDEADBEEF);
    step("rd0", 0, 0, 1, 0, 32'h77, 32'h0, 5'd0);
    check("rd0_we", {31'd0, bus.wb_reg_write}, 32'd0);
    step("st_fl", 0, 1, 0, 1, 32'h40, 32'h0BAD0BAD, 5'd0);
    step("rw_both", 1, 1, 1, 0, 32'h40, 32'h0BAD0BAD, 5'd8);
    idle("rw_both_wait");
    check("both_is_load", bus.wb_data, 32'hDEADBEEF);
    step("st42", 0, 1, 0, 0, 32'h42, 32'hCAFEF00D, 5'd0);
    check("mis_err", {31'd0, bus.misalign_err}, {31'd0, MIS});
    step("ld40c", 1, 0, 1, 0, 32'h40, 32'h0, 5'd2);
    idle("ld40c_wait");
    check("mis_mem", bus.wb_data, MIS ? 32'hDEADBEEF : 32'hCAFEF00D);
    step("ldm", 1, 0, 1, 0, 32'h41, 32'h0, 5'd2);
    check("mis_ld_stall", {31'd0, bus.mem_stall}, {31'd0, !MIS});
    idle("ldm_end");
    step("ldr", 1, 0, 1, 0, 32'h40, 32'h0, 5'd12);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("reset_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    idle("after_reset");
    check("mid_reset_we", {31'd0, bus.wb_reg_write}, 32'd0);
    for (int i = 0; i < 600; i++) begin
      bit r_en, w_en, fl;
      logic [31:0] a;
      r_en = ($urandom_range(0, 3) == 0);
      w_en = ($urandom_range(0, 2) == 0);
      fl   = ($urandom_range(0, 9) == 0);
      a    = {$urandom_range(0, 3) << 10} | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      step("rand", r_en, w_en, 1'($urandom), fl, a, $urandom,
           ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
